pr_reg_seq: RTL and testbench
=============================

Name: pr_reg_seq

Overview:
Register access sequencer that sits directly upstream of the P-R register unit, used by the debug and control-panel path.
- Drives P-R register-select and write controls: {rc,rb,ra}, w_r, as2, strob1_, strob2_, blr.
- Drives the W bus to load user registers R0..R7 from a word stream.
- Consumes the L bus to read R0..R7 back out as a word stream.
- Operates only while the CPU is stopped; all drive is released otherwise.

Parameters:
SETTLE, 2, cycles the address/data are held stable before a capture or strobe (1..15)
STROBE_LEN, 2, cycles strob1_ is held low during a write (1..15)

Ports:
clk_sys  in  1  system clock
rst  in  1  reset, synchronous, active-high
cpu_stopped  in  1  CPU halted; required to start and to continue an operation
req_rd  in  1  one-cycle request: read registers first..last
req_wr  in  1  one-cycle request: write registers first..last
first  in  3  first register index, [0:2]
last  in  3  last register index, [0:2]
busy  out  1  operation in progress
done  out  1  one-cycle pulse on normal completion
abort  out  1  one-cycle pulse when cpu_stopped drops mid-operation
wr_data  in  16  write word, [0:15]
wr_valid  in  1  write word available
wr_ready  out  1  write word accepted this cycle
rd_data  out  16  captured L bus word, [0:15]
rd_idx  out  3  index of rd_data
rd_valid  out  1  read word available
rd_ready  in  1  consumer accepts read word
ra, rb, rc  out  1 each  register select: index[0]→rc, [1]→rb, [2]→ra
w_r  out  1  write-register enable to P-R
as2  out  1  held 0 (strobe A path only)
strob1_  out  1  active-low strobe 1
strob2_  out  1  held 1
blr  out  1  held 0 while busy (unshifted L bus)
w  out  16  W bus drive value
w_oe  out  1  W bus drive enable
l  in  16  P-R L bus

Behaviour:
Reset and idle values (also forced at the first edge with rst=1, including mid-operation):
- busy, done, abort, wr_ready, rd_valid, w_oe, w_r, as2, blr, ra/rb/rc all 0.
- rd_data, rd_idx, w all 0.
- strob1_ and strob2_ both 1.

States:
- IDLE: req_rd or req_wr accepted only when cpu_stopped=1. Latch first; latch dir (rd/wr). Set cur←first. Go to SETUP (rd) or WDATA (wr). If both requests are high, req_rd wins. Requests while busy are ignored.
- WDATA: wr_ready=1. On wr_valid latch wr_data into w, assert w_oe, go to SETUP. wr_ready is high for exactly the accepting cycle.
- SETUP: drive {rc,rb,ra}=cur. Count SETTLE cycles, then go to CAPTURE (rd) or STROBE (wr).
- CAPTURE: rd_data←l, rd_idx←cur, rd_valid←1; go to ROUT.
- ROUT: hold rd_data and rd_valid until rd_ready=1. Clear rd_valid on that edge, go to NEXT.
- STROBE: w_r=1, strob1_=0 for STROBE_LEN cycles; go to HOLD.
- HOLD: strob1_=1, w_r=1, w_oe and address held for one cycle; then drop w_r and w_oe, go to NEXT.
- NEXT: if cur==last, pulse done and go to IDLE. Otherwise cur←cur+1 (3-bit wrap, 7→0) and go to SETUP (rd) or WDATA (wr).

Range, abort and timing rules:
- first==last transfers exactly one register. first>last wraps (e.g. 6..1 is 6,7,0,1). Transfer count = ((last−first) mod 8)+1.
- cpu_stopped=0 in any non-IDLE state: next edge goes to IDLE with abort=1 for one cycle. All outputs take their idle values on that edge; a pending rd_valid is dropped.
- Read latency per register: SETTLE+1 cycles to rd_valid.
- Write per register, from word accept: SETTLE+STROBE_LEN+1 cycles.
- strob1_ never falls in the same cycle that the address or w changes.
- R0 writes go through the same path; the Q-gating of flag bits is P-R's behaviour, not this block's.

Optional Feature:
Macro: PR_REG_SEQ_CHKSUM_EN.
- Defined: adds output chksum[0:15]. Cleared at request accept; chksum←chksum+rd_data (mod 2^16) at each CAPTURE, or +w at each HOLD. Valid when done pulses; held until the next accept.
- Not defined: the port and logic are absent. All other behaviour is identical.

Decomposition:
- Package pr_reg_seq_pkg: state enum (IDLE, WDATA, SETUP, CAPTURE, ROUT, STROBE, HOLD, NEXT), REG_IDX_W=3, WORD_W=16.
- Sub-module pr_reg_seq_cnt: loadable down-counter shared by SETTLE and STROBE_LEN, with zero flag.

Test Plan:
- Read 0..7 with l tracking index·0x1111, rd_ready=1 → 8 words 0x0000..0x7777, rd_idx 0..7, gap SETTLE+2 cycles, single done.
- Write first=3,last=3, wr_data=0xBEEF → {rc,rb,ra}=011, w=0xBEEF, strob1_ low exactly 2 cycles within w_r=1, one HOLD cycle, done.
- Read first=6,last=1 with rd_ready low 5 cycles on word 2 → order 6,7,0,1; rd_data stable while stalled.
- cpu_stopped drops during STROBE → next edge strob1_=1, w_r=0, w_oe=0, abort pulse, busy=0.
- rst asserted mid-read, and req_wr+req_rd together → all outputs at idle values next edge; read wins.
- With PR_REG_SEQ_CHKSUM_EN, read words 0xFFFF,0x0002 → chksum=0x0001 at done.

Source files
------------

// File: rtl/pr_reg_seq_pkg.sv
// Shared types and constants for the P-R register access sequencer.
package pr_reg_seq_pkg;

  localparam int REG_IDX_W = 3;
  localparam int WORD_W    = 16;
  localparam int CNT_W     = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WDATA   = 3'd1,
    SETUP   = 3'd2,
    CAPTURE = 3'd3,
    ROUT    = 3'd4,
    STROBE  = 3'd5,
    HOLD    = 3'd6,
    NEXT    = 3'd7
  } state_e;

  // Register index advance; the 3-bit result wraps 7 -> 0.
  function automatic logic [0:REG_IDX_W-1] idx_inc(input logic [0:REG_IDX_W-1] idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/pr_reg_seq_cnt.sv
// Loadable down-counter timing the settle and strobe phases; saturates at zero.
module pr_reg_seq_cnt
  import pr_reg_seq_pkg::*;
(
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Load on request, otherwise count down and stop at zero.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/pr_reg_seq.sv
// Debug/control-panel sequencer that reads or writes P-R registers R0..R7 while the CPU is stopped.
// Optional running checksum output enabled by defining PR_REG_SEQ_CHKSUM_EN.
module pr_reg_seq
  import pr_reg_seq_pkg::*;
#(
  parameter int SETTLE     = 2,
  parameter int STROBE_LEN = 2
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic                  cpu_stopped,
  input  logic                  req_rd,
  input  logic                  req_wr,
  input  logic [0:REG_IDX_W-1]  first,
  input  logic [0:REG_IDX_W-1]  last,
  output logic                  busy,
  output logic                  done,
  output logic                  abort,
  input  logic [0:WORD_W-1]     wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [0:WORD_W-1]     rd_data,
  output logic [0:REG_IDX_W-1]  rd_idx,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  ra,
  output logic                  rb,
  output logic                  rc,
  output logic                  w_r,
  output logic                  as2,
  output logic                  strob1_,
  output logic                  strob2_,
  output logic                  blr,
  output logic [0:WORD_W-1]     w,
  output logic                  w_oe,
`ifdef PR_REG_SEQ_CHKSUM_EN
  output logic [0:WORD_W-1]     chksum,
`endif
  input  logic [0:WORD_W-1]     l
);

  state_e                 state_r;
  logic [0:REG_IDX_W-1]   cur_r;
  logic [0:REG_IDX_W-1]   last_r;
  logic                   dir_rd_r;

  logic                   accept_s;
  logic                   abort_s;
  logic                   done_s;
  logic                   go_idle_s;
  logic                   cnt_load_s;
  logic [CNT_W-1:0]       cnt_val_s;
  logic                   cnt_zero_s;

  assign as2     = 1'b0;
  assign strob2_ = 1'b1;
  assign blr     = 1'b0;

  pr_reg_seq_cnt u_cnt (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .zero     (cnt_zero_s)
  );

  // Request/exit decode and counter control; the counter is preloaded with SETTLE-1 outside the timed states.
  always_comb begin
    accept_s   = (state_r == IDLE) && cpu_stopped && (req_rd || req_wr);
    abort_s    = (state_r != IDLE) && !cpu_stopped;
    done_s     = (state_r == NEXT) && cpu_stopped && (cur_r == last_r);
    go_idle_s  = abort_s || done_s;
    cnt_load_s = 1'b1;
    cnt_val_s  = CNT_W'(SETTLE - 1);
    if (state_r == SETUP) begin
      cnt_load_s = cnt_zero_s;
      cnt_val_s  = CNT_W'(STROBE_LEN - 1);
    end else if (state_r == STROBE) begin
      cnt_load_s = 1'b0;
    end else begin
      cnt_load_s = 1'b1;
    end
  end

  // Sequencer FSM; every P-R control and stream output is registered here.
  always_ff @(posedge clk_sys) begin
    if (rst || go_idle_s) begin
      state_r      <= IDLE;
      cur_r        <= 3'd0;
      last_r       <= 3'd0;
      dir_rd_r     <= 1'b0;
      busy         <= 1'b0;
      wr_ready     <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= 16'h0000;
      rd_idx       <= 3'd0;
      w            <= 16'h0000;
      w_oe         <= 1'b0;
      w_r          <= 1'b0;
      strob1_      <= 1'b1;
      {rc, rb, ra} <= 3'd0;
      done         <= !rst && done_s;
      abort        <= !rst && abort_s;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            busy     <= 1'b1;
            dir_rd_r <= req_rd;
            cur_r    <= first;
            last_r   <= last;
            if (req_rd) begin
              {rc, rb, ra} <= first;
              state_r      <= SETUP;
            end else begin
              wr_ready <= 1'b1;
              state_r  <= WDATA;
            end
          end
        end
        WDATA: begin
          if (wr_valid) begin
            w            <= wr_data;
            w_oe         <= 1'b1;
            wr_ready     <= 1'b0;
            {rc, rb, ra} <= cur_r;
            state_r      <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_zero_s) begin
            if (dir_rd_r) begin
              state_r <= CAPTURE;
            end else begin
              w_r     <= 1'b1;
              strob1_ <= 1'b0;
              state_r <= STROBE;
            end
          end
        end
        CAPTURE: begin
          rd_data  <= l;
          rd_idx   <= cur_r;
          rd_valid <= 1'b1;
          state_r  <= ROUT;
        end
        ROUT: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            state_r  <= NEXT;
          end
        end
        STROBE: begin
          if (cnt_zero_s) begin
            strob1_ <= 1'b1;
            state_r <= HOLD;
          end
        end
        HOLD: begin
          w_r     <= 1'b0;
          w_oe    <= 1'b0;
          state_r <= NEXT;
        end
        NEXT: begin
          // The last-register case leaves through go_idle_s above.
          cur_r <= idx_inc(cur_r);
          if (dir_rd_r) begin
            {rc, rb, ra} <= idx_inc(cur_r);
            state_r      <= SETUP;
          end else begin
            wr_ready <= 1'b1;
            state_r  <= WDATA;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef PR_REG_SEQ_CHKSUM_EN
  // Running mod-2^16 sum of transferred words, cleared on accept and held after done.
  always_ff @(posedge clk_sys) begin
    if (rst || accept_s) begin
      chksum <= 16'h0000;
    end else if ((state_r == CAPTURE) && !abort_s) begin
      chksum <= chksum + l;
    end else if ((state_r == HOLD) && !abort_s) begin
      chksum <= chksum + w;
    end
  end
`endif

endmodule

// File: tb/tb_pr_reg_seq.sv
// Scoreboard bench for pr_reg_seq: expected reads/writes are queued at request time and matched as words appear.
module tb_pr_reg_seq;

  localparam int SETTLE     = 2;
  localparam int STROBE_LEN = 2;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] data;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_stopped = 1'b1;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic [2:0]  first = 3'd0;
  logic [2:0]  last = 3'd0;
  logic        busy, done, abort;
  logic [15:0] wr_data = 16'h0000;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic [2:0]  rd_idx;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        ra, rb, rc, w_r, as2, strob1_, strob2_, blr, w_oe;
  logic [15:0] w;
  logic [15:0] l;
`ifdef PR_REG_SEQ_CHKSUM_EN
  logic [15:0] chksum;
`endif

  logic [15:0] mem [0:7];
  logic [2:0]  addr_s;
  exp_t        rd_q[$];
  exp_t        wr_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          low_cnt = 0;
  logic        rd_seen = 1'b0;
  logic        first_word = 1'b1;
  logic        gap_en = 1'b0;
  logic        prev_strob = 1'b1;
  logic [2:0]  prev_addr = 3'd0;
  logic [15:0] prev_w = 16'h0000;

  always #5 clk_sys = ~clk_sys;

  assign addr_s = {rc, rb, ra};
  assign l      = mem[addr_s];

  pr_reg_seq #(.SETTLE(SETTLE), .STROBE_LEN(STROBE_LEN)) dut (
    .clk_sys(clk_sys), .rst(rst), .cpu_stopped(cpu_stopped),
    .req_rd(req_rd), .req_wr(req_wr), .first(first), .last(last),
    .busy(busy), .done(done), .abort(abort),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .ra(ra), .rb(rb), .rc(rc), .w_r(w_r), .as2(as2),
    .strob1_(strob1_), .strob2_(strob2_), .blr(blr),
    .w(w), .w_oe(w_oe),
`ifdef PR_REG_SEQ_CHKSUM_EN
    .chksum(chksum),
`endif
    .l(l)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk_sys);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ctl"},
             {18'd0, busy, done, abort, wr_ready, rd_valid, w_oe, w_r, as2, blr, rc, rb, ra, strob1_, strob2_},
             32'h0000_0003);
    check_eq({tag, "_rd_data"}, rd_data, 32'd0);
    check_eq({tag, "_rd_idx"}, rd_idx, 32'd0);
    check_eq({tag, "_w"}, w, 32'd0);
  endtask

  task automatic start_rd(input logic [2:0] f, input logic [2:0] lst);
    logic [2:0] ix;
    int n;
    n  = int'(3'(lst - f)) + 1;
    ix = f;
    for (int i = 0; i < n; i++) begin
      rd_q.push_back('{ix, mem[ix]});
      ix = ix + 3'd1;
    end
    first  = f;
    last   = lst;
    req_rd = 1'b1;
    tick();
    req_rd = 1'b0;
  endtask

  task automatic start_wr(input logic [2:0] f, input logic [15:0] data);
    wr_q.push_back('{f, data});
    first    = f;
    last     = f;
    wr_data  = data;
    wr_valid = 1'b1;
    req_wr   = 1'b1;
    tick();
    req_wr = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq(tag, done_cnt - start, 32'd1);
  endtask

  // Scoreboard monitor: matches each new read word and each strobe against the queued expectations.
  always @(negedge clk_sys) begin
    exp_t e;
    prev_strob <= strob1_;
    prev_addr  <= addr_s;
    prev_w     <= w;
    if (done) done_cnt <= done_cnt + 1;
    if (!busy) begin
      low_cnt <= 0;
      rd_seen <= 1'b0;
      first_word <= 1'b1;
    end else if (!rd_valid) begin
      low_cnt <= low_cnt + 1;
      rd_seen <= 1'b0;
    end else if (!rd_seen) begin
      rd_seen <= 1'b1;
      low_cnt <= 0;
      first_word <= 1'b0;
      if (gap_en) begin
        if (first_word) check_eq("rd_latency", low_cnt, SETTLE + 1);
        else check_eq("rd_gap", low_cnt, SETTLE + 2);
      end
      check_eq("rd_expected", rd_q.size() > 0, 32'd1);
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        check_eq("rd_idx", rd_idx, e.idx);
        check_eq("rd_data", rd_data, e.data);
      end
    end
    if (!strob1_ && prev_strob) begin
      check_eq("wr_expected", wr_q.size() > 0, 32'd1);
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        check_eq("wr_addr", addr_s, e.idx);
        check_eq("wr_w", w, e.data);
        check_eq("wr_addr_settled", prev_addr, e.idx);
        check_eq("wr_w_settled", prev_w, e.data);
        check_eq("wr_oe_wr", {w_oe, w_r}, 32'd3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lo, hold, rdy, n, d0;
    for (int i = 0; i < 8; i++) mem[i] = 16'(i * 16'h1111);

    // Reset values
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    // Full read 0..7 with rd_ready held high
    rd_ready = 1'b1;
    gap_en   = 1'b1;
    d0       = done_cnt;
    start_rd(3'd0, 3'd7);
    check_eq("rd_busy", busy, 32'd1);
    wait_done("rd_all_done", 300);
    repeat (3) tick();
    check_eq("rd_all_single_done", done_cnt - d0, 32'd1);
    check_eq("rd_all_q_empty", rd_q.size(), 32'd0);
    check_idle("rd_all_end");

    // Single write R3 = 0xBEEF: strobe shape and hold
    lo = 0; hold = 0; rdy = 0; n = 0;
    start_wr(3'd3, 16'hBEEF);
    while (!done && n < 40) begin
      if (!strob1_) begin
        lo++;
        check_eq("wr_strobe_in_wr", w_r, 32'd1);
      end
      if (w_r && strob1_) hold++;
      if (wr_ready) rdy++;
      if (w_r) check_eq("wr_drive", {13'd0, addr_s, w}, {13'd0, 3'b011, 16'hBEEF});
      tick();
      n++;
    end
    wr_valid = 1'b0;
    check_eq("wr_done", done, 32'd1);
    check_eq("wr_strobe_len", lo, STROBE_LEN);
    check_eq("wr_hold_len", hold, 32'd1);
    check_eq("wr_ready_cycles", rdy, 32'd1);
    check_eq("wr_q_empty", wr_q.size(), 32'd0);
    tick();

    // Wrapping read 6..1 with a 5-cycle stall on the third word
    start_rd(3'd6, 3'd1);
    n = 0;
    while (!(rd_valid && rd_idx == 3'd7) && n < 60) begin tick(); n++; end
    check_eq("stall_saw_r7", {rd_valid, rd_idx}, 32'hF);
    tick();
    rd_ready = 1'b0;
    n = 0;
    while (!rd_valid && n < 60) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_hold", {rd_valid, rd_idx, rd_data}, {13'd0, 1'b1, 3'd0, mem[0]});
      tick();
    end
    rd_ready = 1'b1;
    wait_done("wrap_done", 100);
    check_eq("wrap_q_empty", rd_q.size(), 32'd0);
    gap_en = 1'b0;

    // cpu_stopped drops during STROBE
    start_wr(3'd0, 16'h1234);
    n = 0;
    while (strob1_ && n < 40) begin tick(); n++; end
    check_eq("abort_in_strobe", strob1_, 32'd0);
    cpu_stopped = 1'b0;
    tick();
    check_eq("abort_outputs", {strob1_, w_r, w_oe, abort, busy}, 32'b10010);
    tick();
    check_eq("abort_one_cycle", abort, 32'd0);
    cpu_stopped = 1'b1;
    wr_valid    = 1'b0;
    check_eq("abort_wr_q_empty", wr_q.size(), 32'd0);

    // Reset in the middle of a read
    rd_ready = 1'b0;
    start_rd(3'd0, 3'd7);
    tick();
    rst = 1'b1;
    tick();
    check_idle("rst_mid");
    check_eq("rst_mid_abort", abort, 32'd0);
    rst = 1'b0;
    rd_q.delete();
    tick();

    // Requests while the CPU runs are ignored
    cpu_stopped = 1'b0;
    first = 3'd0; last = 3'd0; req_rd = 1'b1;
    tick();
    req_rd = 1'b0;
    check_eq("run_ignored", busy, 32'd0);
    cpu_stopped = 1'b1;
    tick();

    // Simultaneous requests: read wins
    rd_q.push_back('{3'd2, mem[2]});
    first = 3'd2; last = 3'd2; req_rd = 1'b1; req_wr = 1'b1;
    tick();
    req_rd = 1'b0; req_wr = 1'b0;
    check_eq("both_req_read", {busy, wr_ready}, 32'b10);
    rd_ready = 1'b1;
    wait_done("both_done", 60);
    check_eq("both_q_empty", rd_q.size(), 32'd0);

`ifdef PR_REG_SEQ_CHKSUM_EN
    // Checksum wraps mod 2^16
    mem[0] = 16'hFFFF;
    mem[1] = 16'h0002;
    start_rd(3'd0, 3'd1);
    wait_done("chk_done", 60);
    check_eq("chksum", chksum, 32'h0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
